scaled_counter: RTL and testbench
=================================

# scaled_counter

Parametrised up/down counter that advances on a prescaled tick rather than on a derived clock, with synchronous load, wrap or saturate overflow mode, and overflow and limit indications. It replaces ad-hoc divided-clock counters in input-handling and sandbox designs. Everything runs in the single `clock` domain. It feeds display and position logic that samples `value`.

## Interface
- `WIDTH`, 8: counter width in bits; must be ≥2.
- `LOAD_WIDTH`, 16: width of `load_value`; must be ≥`WIDTH`. Only the low `WIDTH` bits are used.
- `DIVIDE`, 2: prescale ratio. One tick every `DIVIDE` clocks. Must be ≥1.
- `RESET_VALUE`, all ones (`'1`): value of the counter after reset.
- `MODE`, `SC_WRAP`: overflow behaviour, either `SC_WRAP` or `SC_SATURATE`.

Ports:
- `clock`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `restart`  in  1: synchronous prescaler clear. Does not affect `value`.
- `enable`  in  1: count enable, sampled on tick cycles.
- `up`  in  1: direction, sampled on tick cycles. 1 means +1, 0 means −1.
- `load`  in  1: synchronous load, sampled on tick cycles.
- `load_value`  in  `LOAD_WIDTH`: load source; bits [`WIDTH`-1:0] are taken.
- `value`  out  `WIDTH`: registered counter value.
- `tick`  out  1: combinational; high in the cycle in which an update is applied.
- `wrapped`  out  1: registered one-cycle pulse on a wrap event.
- `at_limit`  out  1: registered one-cycle pulse when saturation blocks a step.

## Operation
- The prescaler `div` counts 0..`DIVIDE`-1 and wraps to 0.
  - `tick` = (`div` == `DIVIDE`-1) and not `restart`.
  - With `DIVIDE`=1, `tick` = not `restart`.
- `restart` high: `div` goes to 0 on the next edge and no update is applied in that cycle.
- On a tick cycle, priority is `load` > (`enable`, `up`/down) > hold:
  - `load`: `value` ← `load_value`[`WIDTH`-1:0]. `wrapped` and `at_limit` stay 0.
  - `enable` & `up`: `value` ← `value`+1.
  - `enable` & not `up`: `value` ← `value`−1.
  - `enable` low: hold.
- Arithmetic is `WIDTH`-bit unsigned.
- `SC_WRAP` mode:
  - max+1 gives 0; 0−1 gives max.
  - Either wrap pulses `wrapped` for one cycle, together with the value update.
- `SC_SATURATE` mode:
  - max+1 stays max; 0−1 stays 0.
  - A blocked step pulses `at_limit` for one cycle. `wrapped` is never asserted.
- On non-tick cycles, `load`, `enable` and `up` are ignored and `value` holds. Inputs are not latched.

## Timing
- Reset (asynchronous, any time):
  - `value`=`RESET_VALUE`, `div`=0.
  - `wrapped`=0, `at_limit`=0.
  - `tick` is 0 while `reset` is high.
- After reset release, the first tick is in the `DIVIDE`th cycle: `div` reaches `DIVIDE`-1.
- Latency: inputs sampled in a tick cycle appear on `value`, `wrapped` and `at_limit` after the next rising edge (1 clock).
- Update rate: at most one update per `DIVIDE` clocks with no `restart`.
- Reset mid-count: the prescaler phase is lost and counting resumes with the full `DIVIDE` interval.
- `restart` in a tick cycle: the tick is suppressed and the next tick comes `DIVIDE` cycles later.
- `load` together with an overflow condition: the load wins and no pulse is generated.

## Structure
- Package `scaled_counter_pkg` holds:
  - typedef enum `sc_mode_t` {`SC_WRAP`, `SC_SATURATE`};
  - the helper function for the prescaler width, `$clog2(DIVIDE)` with a minimum of 1.
- Sub-module `tick_divider`:
  - parameter `DIVIDE`;
  - ports `clock`, `reset`, `restart`, `tick`.
  - It is reused by other rate-limited blocks.
- Elaboration-time assertions: `DIVIDE`≥1, `LOAD_WIDTH`≥`WIDTH`, `WIDTH`≥2.

## Test plan
- Reset with defaults:
  - `value`=8'hFF immediately, without a clock edge.
  - After release with `enable`=1 and `up`=1, `tick` is high every 2nd cycle.
  - `value` goes FF→00 with `wrapped`=1 for one cycle, then 01, 02.
- Load with `DIVIDE`=4, `load`=1, `load_value`=16'h12A5:
  - `value`=8'hA5 one cycle after the tick.
  - Holding `load` in non-tick cycles has no effect.
- `SC_SATURATE` mode, `WIDTH`=4:
  - Load 4'hE and count up 3 ticks: `value` goes E→F→F→F.
  - `at_limit` pulses on the 2nd and 3rd updates.
  - Then count down from 0: `value` stays 0 and `at_limit` pulses.
- `restart` pulsed every 3 cycles with `DIVIDE`=4:
  - `tick` is never asserted and `value` holds.
  - Releasing `restart`: the first tick comes exactly 4 cycles later.
- Asynchronous reset mid-count, asserted between edges with `RESET_VALUE`=8'h40:
  - `value`=40 before the next edge.
  - `wrapped` and `at_limit` clear, and the prescaler restarts from 0.
- `DIVIDE`=1, `enable` toggling every cycle, `up`=0 from 8'h01:
  - `value` updates on alternate cycles: 01→00, then →FF with `wrapped`=1.

Source files
------------

// File: rtl/scaled_counter_pkg.sv
// Shared types and helpers for the prescaled counter and its tick divider.
package scaled_counter_pkg;

    typedef enum logic {
        SC_WRAP,
        SC_SATURATE
    } sc_mode_t;

    // A divide-by-1 prescaler still needs a one-bit register to stay legal.
    function automatic int div_width(input int divide);
        return (divide <= 2) ? 1 : $clog2(divide);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: one tick every DIVIDE clocks, cleared by restart.
module tick_divider
    import scaled_counter_pkg::*;
#(
    parameter int DIVIDE = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int DW = div_width(DIVIDE);
    localparam logic [DW-1:0] LAST = DW'(DIVIDE - 1);
    localparam logic [DW-1:0] STEP = DW'(1);

    if (DIVIDE < 1) begin : g_divide_check
        $error("tick_divider: DIVIDE must be at least 1");
    end

    logic [DW-1:0] div;

    // Gated by reset so no update can be signalled while the block is held.
    assign tick = !reset && !restart && (div == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (restart || div == LAST) begin
            div <= '0;
        end else begin
            div <= div + STEP;
        end
    end

endmodule

// File: rtl/scaled_counter.sv
// Up/down counter advancing on a prescaled tick, with load, wrap/saturate
// overflow handling and one-cycle wrapped / at_limit pulses.
module scaled_counter
    import scaled_counter_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter int              LOAD_WIDTH  = 16,
    parameter int              DIVIDE      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1,
    parameter sc_mode_t        MODE        = SC_WRAP
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [LOAD_WIDTH-1:0] load_value,
    output logic [WIDTH-1:0]      value,
    output logic                  tick,
    output logic                  wrapped,
    output logic                  at_limit
);

    localparam logic [WIDTH-1:0] MAX_VALUE = '1;
    localparam logic [WIDTH-1:0] MIN_VALUE = '0;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    if (WIDTH < 2) begin : g_width_check
        $error("scaled_counter: WIDTH must be at least 2");
    end
    if (LOAD_WIDTH < WIDTH) begin : g_load_width_check
        $error("scaled_counter: LOAD_WIDTH must be at least WIDTH");
    end
    if (DIVIDE < 1) begin : g_divide_check
        $error("scaled_counter: DIVIDE must be at least 1");
    end

    logic [WIDTH-1:0] value_next;
    logic             wrapped_next;
    logic             at_limit_next;
    logic             load_unused_bits;

    // Upper load bits are accepted for port compatibility but never stored.
    assign load_unused_bits = ^load_value;

    tick_divider #(
        .DIVIDE (DIVIDE)
    ) u_tick_divider (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        value_next    = value;
        wrapped_next  = 1'b0;
        at_limit_next = 1'b0;
        if (tick) begin
            if (load) begin
                value_next = load_value[WIDTH-1:0];
            end else if (enable && up) begin
                if (value == MAX_VALUE) begin
                    if (MODE == SC_SATURATE) begin
                        at_limit_next = 1'b1;
                    end else begin
                        value_next   = MIN_VALUE;
                        wrapped_next = 1'b1;
                    end
                end else begin
                    value_next = value + ONE;
                end
            end else if (enable) begin
                if (value == MIN_VALUE) begin
                    if (MODE == SC_SATURATE) begin
                        at_limit_next = 1'b1;
                    end else begin
                        value_next   = MAX_VALUE;
                        wrapped_next = 1'b1;
                    end
                end else begin
                    value_next = value - ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value    <= RESET_VALUE;
            wrapped  <= 1'b0;
            at_limit <= 1'b0;
        end else begin
            value    <= value_next;
            wrapped  <= wrapped_next;
            at_limit <= at_limit_next;
        end
    end

endmodule

// File: tb/tb_scaled_counter.sv
// Bench for scaled_counter: four parameterisations share one stimulus stream
// and are checked every cycle against an arithmetic model.
module tb_scaled_counter;
    import scaled_counter_pkg::*;

    localparam int NDUT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic        enable = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;

    logic [7:0] value_a, value_b, value_d;
    logic [3:0] value_c;
    logic tick_a, tick_b, tick_c, tick_d;
    logic wrapped_a, wrapped_b, wrapped_c, wrapped_d;
    logic at_limit_a, at_limit_b, at_limit_c, at_limit_d;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    always #5 clock = ~clock;

    // a: defaults; b: DIVIDE 4, reset value 40; c: 4-bit saturating, DIVIDE 3; d: DIVIDE 1
    scaled_counter dut_a (
        .clock(clock), .reset(reset), .restart(restart), .enable(enable), .up(up),
        .load(load), .load_value(load_value), .value(value_a), .tick(tick_a),
        .wrapped(wrapped_a), .at_limit(at_limit_a));

    scaled_counter #(.WIDTH(8), .LOAD_WIDTH(16), .DIVIDE(4), .RESET_VALUE(8'h40), .MODE(SC_WRAP)) dut_b (
        .clock(clock), .reset(reset), .restart(restart), .enable(enable), .up(up),
        .load(load), .load_value(load_value), .value(value_b), .tick(tick_b),
        .wrapped(wrapped_b), .at_limit(at_limit_b));

    scaled_counter #(.WIDTH(4), .LOAD_WIDTH(16), .DIVIDE(3), .RESET_VALUE(4'hF), .MODE(SC_SATURATE)) dut_c (
        .clock(clock), .reset(reset), .restart(restart), .enable(enable), .up(up),
        .load(load), .load_value(load_value), .value(value_c), .tick(tick_c),
        .wrapped(wrapped_c), .at_limit(at_limit_c));

    scaled_counter #(.WIDTH(8), .LOAD_WIDTH(16), .DIVIDE(1), .RESET_VALUE(8'hFF), .MODE(SC_WRAP)) dut_d (
        .clock(clock), .reset(reset), .restart(restart), .enable(enable), .up(up),
        .load(load), .load_value(load_value), .value(value_d), .tick(tick_d),
        .wrapped(wrapped_d), .at_limit(at_limit_d));

    int div_of[NDUT]   = '{2, 4, 3, 1};
    int width_of[NDUT] = '{8, 8, 4, 8};
    int reset_of[NDUT] = '{255, 64, 15, 255};
    bit sat_of[NDUT]   = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Model: n = clocks since the last reset or restart; everything else is arithmetic.
    int n = 0;
    int mv[NDUT];
    int mw[NDUT];
    int ma[NDUT];

    function automatic bit model_tick(input int i);
        return !reset && !restart && ((n % div_of[i]) == div_of[i] - 1);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            n = 0;
            for (int i = 0; i < NDUT; i++) begin
                mv[i] = reset_of[i];
                mw[i] = 0;
                ma[i] = 0;
            end
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                int lim;
                lim = (1 << width_of[i]) - 1;
                mw[i] = 0;
                ma[i] = 0;
                if (model_tick(i)) begin
                    if (load) begin
                        mv[i] = int'(load_value) & lim;
                    end else if (enable && up) begin
                        if (mv[i] == lim) begin
                            if (sat_of[i]) ma[i] = 1;
                            else begin mv[i] = 0; mw[i] = 1; end
                        end else mv[i] = mv[i] + 1;
                    end else if (enable) begin
                        if (mv[i] == 0) begin
                            if (sat_of[i]) ma[i] = 1;
                            else begin mv[i] = lim; mw[i] = 1; end
                        end else mv[i] = mv[i] - 1;
                    end
                end
            end
            n = restart ? 0 : n + 1;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            int act_v[NDUT];
            int act_t[NDUT];
            int act_w[NDUT];
            int act_a[NDUT];
            act_v = '{int'(value_a), int'(value_b), int'(value_c), int'(value_d)};
            act_t = '{int'(tick_a), int'(tick_b), int'(tick_c), int'(tick_d)};
            act_w = '{int'(wrapped_a), int'(wrapped_b), int'(wrapped_c), int'(wrapped_d)};
            act_a = '{int'(at_limit_a), int'(at_limit_b), int'(at_limit_c), int'(at_limit_d)};
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("model_tick[%0d]", i), act_t[i], int'(model_tick(i)));
                check($sformatf("model_value[%0d]", i), act_v[i], mv[i]);
                check($sformatf("model_wrapped[%0d]", i), act_w[i], mw[i]);
                check($sformatf("model_at_limit[%0d]", i), act_a[i], ma[i]);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic align();
        cyc(); restart = 1'b1;
        cyc(); restart = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("reset_value_a", int'(value_a), 'hFF);
        check("reset_value_b", int'(value_b), 'h40);
        check("reset_value_c", int'(value_c), 'hF);
        check("reset_tick_d", int'(tick_d), 0);
        checking = 1'b1;

        // Default instance: FF -> 00 with wrapped, then 01, 02 on every 2nd clock
        cyc(); cyc(); reset = 1'b0; enable = 1'b1; up = 1'b1;
        mid(); check("a_tick_first", int'(tick_a), 0); check("d_tick_first", int'(tick_d), 1);
        cyc(); mid(); check("a_tick_second", int'(tick_a), 1); check("a_value_ff", int'(value_a), 'hFF);
        cyc(); mid(); check("a_value_00", int'(value_a), 'h00); check("a_wrapped", int'(wrapped_a), 1);
        cyc(); mid(); check("a_wrapped_clear", int'(wrapped_a), 0); check("a_tick_again", int'(tick_a), 1);
        cyc(); mid(); check("a_value_01", int'(value_a), 'h01);
        cyc(); cyc(); mid(); check("a_value_02", int'(value_a), 'h02);

        // Load on DIVIDE=4 only takes effect in the tick cycle
        align(); load = 1'b1; load_value = 16'h12A5; enable = 1'b0;
        mid(); check("b_load_tick_n0", int'(tick_b), 0);
        cyc(); mid(); check("b_load_tick_n1", int'(tick_b), 0);
        cyc(); mid(); check("b_load_tick_n2", int'(tick_b), 0); check("a_load_a5", int'(value_a), 'hA5);
        cyc(); mid(); check("b_load_tick_n3", int'(tick_b), 1);
        cyc(); load = 1'b0; mid(); check("b_load_a5", int'(value_b), 'hA5);

        // Saturating 4-bit instance: E -> F -> F -> F, at_limit on the blocked steps
        align(); load = 1'b1; load_value = 16'h000E; enable = 1'b1; up = 1'b1;
        cyc(); cyc(); cyc(); load = 1'b0; mid(); check("c_value_e", int'(value_c), 'hE);
        cyc(); cyc(); cyc(); mid(); check("c_value_f", int'(value_c), 'hF); check("c_no_limit", int'(at_limit_c), 0);
        cyc(); cyc(); cyc(); mid(); check("c_limit_1", int'(at_limit_c), 1); check("c_hold_f1", int'(value_c), 'hF);
        check("c_never_wraps", int'(wrapped_c), 0);
        cyc(); mid(); check("c_limit_pulse", int'(at_limit_c), 0);
        cyc(); cyc(); mid(); check("c_limit_2", int'(at_limit_c), 1); check("c_hold_f2", int'(value_c), 'hF);

        align(); load = 1'b1; load_value = 16'h0000; up = 1'b0;
        cyc(); cyc(); cyc(); load = 1'b0; mid(); check("c_value_0", int'(value_c), 0);
        cyc(); cyc(); cyc(); mid(); check("c_floor_0", int'(value_c), 0); check("c_floor_limit", int'(at_limit_c), 1);

        // restart every 3rd cycle starves the DIVIDE=4 instance
        up = 1'b1;
        for (int k = 0; k < 13; k++) begin
            cyc(); restart = (k % 3 == 0);
            mid(); check("b_tick_starved", int'(tick_b), 0);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(); restart = 1'b0;
            mid(); check("b_tick_after_restart", int'(tick_b), int'(k == 3));
        end

        // DIVIDE=1, down from 01 with enable toggling
        cyc(); load = 1'b1; load_value = 16'h0001; enable = 1'b0;
        cyc(); load = 1'b0; up = 1'b0; enable = 1'b1; mid(); check("d_value_01", int'(value_d), 'h01);
        cyc(); enable = 1'b0; mid(); check("d_value_00", int'(value_d), 'h00);
        cyc(); enable = 1'b1; mid(); check("d_hold_00", int'(value_d), 'h00);
        cyc(); enable = 1'b0; mid(); check("d_value_ff", int'(value_d), 'hFF); check("d_wrapped", int'(wrapped_d), 1);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("async_value_b", int'(value_b), 'h40);
        check("async_wrapped_d", int'(wrapped_d), 0);
        check("async_tick_d", int'(tick_d), 0);
        check("async_at_limit_c", int'(at_limit_c), 0);
        cyc();
        cyc(); reset = 1'b0; enable = 1'b0;
        mid(); check("b_post_reset_n0", int'(tick_b), 0);
        cyc(); mid(); check("b_post_reset_n1", int'(tick_b), 0);
        cyc(); mid(); check("b_post_reset_n2", int'(tick_b), 0);
        cyc(); mid(); check("b_post_reset_n3", int'(tick_b), 1);
        cyc(); mid(); check("b_post_reset_hold", int'(value_b), 'h40);

        cyc(); cyc();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
